muldiv_sequencer: RTL and testbench

- Sequences the RV32M multiply/divide resource for the EX stage of the RV32IM pipeline.
- Accepts one M-extension operation at a time, then stalls the pipeline via BUSY while the operation runs:
  - multiply: single registered 64-bit product;
  - divide/remainder: 32-iteration restoring divide.
- Returns a one-cycle VALID pulse with RESULT and the destination register tag for writeback.
- A pipeline flush aborts the operation in flight.

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_sequencer_div_step.sv | 24 ++
 rtl/muldiv_sequencer.sv | 140 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: op selectors,
// FSM states and the arithmetic corner-case constants.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Magnitude of v when it is to be read as signed, raw value otherwise.
  function automatic logic [31:0] cond_abs(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_sequencer_div_step.sv
// One combinational restoring-division iteration on a {rem, quo} pair.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  // The shifted partial remainder needs one extra bit: rem can reach 2^XLEN-2.
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          borrow;

  always_comb begin
    shifted          = {rem, quo[XLEN-1]};
    {borrow, diff}   = {1'b0, shifted} - {2'b00, divisor};
    rem_next         = XLEN'(borrow ? shifted : diff);
    quo_next         = {quo[XLEN-2:0], ~borrow};
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer for the EX stage: one registered multiply,
// 32-step restoring divide, one-cycle VALID pulse back to writeback.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic            FLUSH,
  input  logic [2:0]      FUNCT3,
  input  logic [XLEN-1:0] OPERAND1,
  input  logic [XLEN-1:0] OPERAND2,
  input  logic [4:0]      DEST_IN,
  output logic            BUSY,
  output logic            VALID,
  output logic [XLEN-1:0] RESULT,
  output logic [4:0]      DEST_OUT
);

  state_t            state, state_nx;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   op1_q, op2_q;
  logic [XLEN-1:0]   rem_q, quo_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   result_nx;

  logic              accept;
  logic              in_signed, in_rem, in_div0, in_ovf;
  logic              div_signed;
  logic [XLEN-1:0]   dvsr;
  logic [XLEN-1:0]   rem_step, quo_step;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic              mul_s1, mul_s2;
  logic [2*XLEN-1:0] mul_a, mul_b, prod;

  assign accept    = (state == S_IDLE) && START && !FLUSH;
  assign in_signed = ~FUNCT3[0];
  assign in_rem    = FUNCT3[1];
  assign in_div0   = (OPERAND2 == '0);
  assign in_ovf    = in_signed && (OPERAND1 == INT_MIN) && (OPERAND2 == NEG_ONE);

  assign div_signed = ~f3_q[0];
  assign dvsr       = cond_abs(op2_q, div_signed);

  div_step #(.XLEN(XLEN)) u_div_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvsr),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  // Sign-extending both operands to 2*XLEN makes one unsigned multiply
  // correct for every signedness combination in the low 2*XLEN bits.
  assign mul_s1 = (f3_q == F3_MULH) || (f3_q == F3_MULHSU);
  assign mul_s2 = (f3_q == F3_MULH);
  assign mul_a  = {{XLEN{mul_s1 & op1_q[XLEN-1]}}, op1_q};
  assign mul_b  = {{XLEN{mul_s2 & op2_q[XLEN-1]}}, op2_q};
  assign prod   = mul_a * mul_b;

  assign quo_fix = (div_signed && (op1_q[XLEN-1] ^ op2_q[XLEN-1])) ? (~quo_q + 1'b1) : quo_q;
  assign rem_fix = (div_signed && op1_q[XLEN-1]) ? (~rem_q + 1'b1) : rem_q;

  always_comb begin
    state_nx  = state;
    result_nx = RESULT;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (!FUNCT3[2]) begin
            state_nx = S_MUL;
          end else if (in_div0) begin
            state_nx  = S_DONE;
            result_nx = in_rem ? OPERAND1 : NEG_ONE;
          end else if (in_ovf) begin
            state_nx  = S_DONE;
            result_nx = in_rem ? '0 : INT_MIN;
          end else begin
            state_nx = S_DIV;
          end
        end
      end
      S_MUL: begin
        state_nx  = S_DONE;
        result_nx = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      end
      S_DIV: begin
        if (cnt_q == CNT_W'(XLEN - 1)) state_nx = S_FIX;
      end
      S_FIX: begin
        state_nx  = S_DONE;
        result_nx = f3_q[1] ? rem_fix : quo_fix;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (FLUSH && (state != S_IDLE)) begin
      state_nx  = S_IDLE;
      result_nx = RESULT;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_IDLE;
      BUSY     <= 1'b0;
      VALID    <= 1'b0;
      RESULT   <= '0;
      DEST_OUT <= '0;
      f3_q     <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state  <= state_nx;
      BUSY   <= (state_nx != S_IDLE);
      VALID  <= (state_nx == S_DONE);
      RESULT <= result_nx;
      if (accept) begin
        f3_q     <= FUNCT3;
        op1_q    <= OPERAND1;
        op2_q    <= OPERAND2;
        DEST_OUT <= DEST_IN;
        cnt_q    <= '0;
        rem_q    <= '0;
        quo_q    <= cond_abs(OPERAND1, in_signed);
      end else if (state == S_DIV) begin
        rem_q <= rem_step;
        quo_q <= quo_step;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table plus flush/reset/stall sequences.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET, START, FLUSH;
  logic [2:0]  FUNCT3;
  logic [31:0] OPERAND1, OPERAND2;
  logic [4:0]  DEST_IN;
  logic        BUSY, VALID;
  logic [31:0] RESULT;
  logic [4:0]  DEST_OUT;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_sequencer #(.XLEN(32), .CNT_W(5)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .FLUSH(FLUSH),
    .FUNCT3(FUNCT3), .OPERAND1(OPERAND1), .OPERAND2(OPERAND2), .DEST_IN(DEST_IN),
    .BUSY(BUSY), .VALID(VALID), .RESULT(RESULT), .DEST_OUT(DEST_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dest;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called in the negedge phase; waits for IDLE, then presents one request.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] dest, input string name);
    int w = 0;
    while (BUSY && w < 200) begin
      @(negedge CLK);
      w++;
    end
    check({name, " idle wait"}, 32'(w < 200), 32'd1);
    FUNCT3 = f3; OPERAND1 = a; OPERAND2 = b; DEST_IN = dest; START = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    check({name, " accept busy"}, 32'(BUSY), 32'd1);
  endtask

  // n counts from 1 at the first negedge after the accept edge.
  task automatic await_valid(output int n);
    n = 1;
    while (!VALID && n < 200) begin
      @(negedge CLK);
      n++;
    end
  endtask

  initial begin
    int    n;
    int    pulses;
    string nm;
    logic [31:0] last_exp;

    tbl[0]  = '{F3_MUL,    32'd7,         32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, 2};
    tbl[1]  = '{F3_MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF, 5'd5,  32'hFFFFFFFE, 2};
    tbl[2]  = '{F3_MULH,   32'hFFFFFFFF,  32'hFFFFFFFF, 5'd6,  32'h00000000, 2};
    tbl[3]  = '{F3_MULHSU, 32'hFFFFFFFF,  32'hFFFFFFFF, 5'd7,  32'hFFFFFFFF, 2};
    tbl[4]  = '{F3_DIV,    32'hFFFFFFEC,  32'd3,        5'd8,  32'hFFFFFFFA, 34};
    tbl[5]  = '{F3_REM,    32'hFFFFFFEC,  32'd3,        5'd9,  32'hFFFFFFFE, 34};
    tbl[6]  = '{F3_DIVU,   32'd5,         32'd0,        5'd10, 32'hFFFFFFFF, 1};
    tbl[7]  = '{F3_REMU,   32'd5,         32'd0,        5'd11, 32'd5,        1};
    tbl[8]  = '{F3_DIV,    32'h80000000,  32'hFFFFFFFF, 5'd12, 32'h80000000, 1};
    tbl[9]  = '{F3_REM,    32'h80000000,  32'hFFFFFFFF, 5'd13, 32'h00000000, 1};
    tbl[10] = '{F3_DIVU,   32'hFFFFFFFF,  32'h80000001, 5'd14, 32'h00000001, 34};
    tbl[11] = '{F3_REMU,   32'hFFFFFFFF,  32'h80000001, 5'd15, 32'h7FFFFFFE, 34};
    tbl[12] = '{F3_DIV,    32'h80000000,  32'd2,        5'd16, 32'hC0000000, 34};
    tbl[13] = '{F3_REM,    32'd7,         32'hFFFFFFFE, 5'd17, 32'd1,        34};
    tbl[14] = '{F3_MUL,    32'h12345678,  32'h10,       5'd31, 32'h23456780, 2};

    RESET = 1'b1; START = 1'b0; FLUSH = 1'b0;
    FUNCT3 = '0; OPERAND1 = '0; OPERAND2 = '0; DEST_IN = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset busy",   32'(BUSY),     32'd0);
    check("reset valid",  32'(VALID),    32'd0);
    check("reset result", RESULT,        32'd0);
    check("reset dest",   32'(DEST_OUT), 32'd0);
    RESET = 1'b0;
    @(negedge CLK);

    // Consecutive entries also exercise back-to-back acceptance after DONE.
    for (int i = 0; i < 15; i++) begin
      nm = $sformatf("vec%0d", i);
      issue(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].dest, nm);
      await_valid(n);
      check({nm, " latency"}, 32'(n),        32'(tbl[i].lat));
      check({nm, " result"},  RESULT,        tbl[i].exp);
      check({nm, " dest"},    32'(DEST_OUT), 32'(tbl[i].dest));
      check({nm, " busy@valid"}, 32'(BUSY),  32'd1);
      @(negedge CLK);
      check({nm, " valid width"}, 32'(VALID), 32'd0);
      check({nm, " busy drop"},   32'(BUSY),  32'd0);
    end
    last_exp = tbl[14].exp;

    // Flush in the 10th DIV cycle: no VALID, RESULT untouched.
    issue(F3_DIV, 32'd1000, 32'd3, 5'd20, "flush");
    repeat (9) @(negedge CLK);
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
    check("flush busy",   32'(BUSY),  32'd0);
    check("flush valid",  32'(VALID), 32'd0);
    check("flush result", RESULT,     last_exp);
    pulses = 0;
    repeat (40) begin
      @(negedge CLK);
      if (VALID) pulses++;
    end
    check("flush no valid", 32'(pulses), 32'd0);
    issue(F3_DIVU, 32'd100, 32'd7, 5'd21, "post-flush");
    await_valid(n);
    check("post-flush latency", 32'(n),        32'd34);
    check("post-flush result",  RESULT,        32'd14);
    check("post-flush dest",    32'(DEST_OUT), 32'd21);
    @(negedge CLK);

    // START with other operands while busy must not disturb the operation.
    issue(F3_DIV, 32'hFFFFFFEC, 32'd3, 5'd22, "stall");
    FUNCT3 = F3_REMU; OPERAND1 = 32'd77; OPERAND2 = 32'd5; DEST_IN = 5'd1; START = 1'b1;
    await_valid(n);
    START = 1'b0;
    check("stall latency", 32'(n),        32'd34);
    check("stall result",  RESULT,        32'hFFFFFFFA);
    check("stall dest",    32'(DEST_OUT), 32'd22);
    @(negedge CLK);
    check("stall no reaccept", 32'(BUSY), 32'd0);

    // START and FLUSH together in IDLE: flush wins.
    START = 1'b1; FLUSH = 1'b1;
    FUNCT3 = F3_MUL; OPERAND1 = 32'd3; OPERAND2 = 32'd3; DEST_IN = 5'd2;
    @(negedge CLK);
    START = 1'b0; FLUSH = 1'b0;
    check("start+flush busy",  32'(BUSY),  32'd0);
    @(negedge CLK);
    check("start+flush valid", 32'(VALID), 32'd0);
    check("start+flush busy2", 32'(BUSY),  32'd0);

    // Reset in the middle of a divide clears every output.
    issue(F3_DIVU, 32'd12345, 32'd11, 5'd23, "mid-reset");
    repeat (5) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("mid-reset busy",   32'(BUSY),     32'd0);
    check("mid-reset valid",  32'(VALID),    32'd0);
    check("mid-reset result", RESULT,        32'd0);
    check("mid-reset dest",   32'(DEST_OUT), 32'd0);
    issue(F3_REMU, 32'd12345, 32'd11, 5'd24, "post-reset");
    await_valid(n);
    check("post-reset latency", 32'(n), 32'd34);
    check("post-reset result",  RESULT, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
